// File: rtl/gcd_lcm_coproc_pkg.sv
// Shared definitions for the GCD/LCM coprocessor: register map, bit positions
// and controller states.
package gcd_lcm_pkg;

    localparam logic [31:0] OFF_OPA      = 32'd0;
    localparam logic [31:0] OFF_OPB      = 32'd4;
    localparam logic [31:0] OFF_CTRL     = 32'd8;
    localparam logic [31:0] OFF_STATUS   = 32'd12;
    localparam logic [31:0] OFF_RESULT   = 32'd16;
    localparam logic [31:0] WINDOW_BYTES = 32'd20;

    localparam int CTRL_START  = 0;
    localparam int CTRL_MODE   = 1;
    localparam int ST_BUSY     = 0;
    localparam int ST_DONE     = 1;
    localparam int ST_ZERO_ERR = 2;
    localparam int ST_OVF      = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GCD   = 3'd1,
        CHECK = 3'd2,
        DIV   = 3'd3,
        MUL   = 3'd4,
        DONE  = 3'd5
    } state_e;

    typedef enum logic {
        MODE_GCD = 1'b0,
        MODE_LCM = 1'b1
    } mode_e;

endpackage

// File: rtl/gcd_lcm_coproc_if.sv
// Core data-memory store/load bus as seen by the coprocessor, plus its status
// strobes.
interface gcd_lcm_coproc_if #(
    parameter int WIDTH = 32
);
    logic             MemWrite;
    logic [31:0]      DataAdr;
    logic [WIDTH-1:0] WriteData;
    logic [WIDTH-1:0] rd_data;
    logic             sel;
    logic             busy;
    logic             done;

    modport master (
        output MemWrite, DataAdr, WriteData,
        input  rd_data, sel, busy, done
    );

    modport slave (
        input  MemWrite, DataAdr, WriteData,
        output rd_data, sel, busy, done
    );
endinterface

// File: rtl/gcd_lcm_coproc_seq_divider.sv
// Restoring unsigned divider. The start edge already performs the first
// quotient bit, so valid rises in the WIDTH-th cycle after start.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic             valid
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] src_quo_s, src_rem_s, new_rem_s;
    logic [WIDTH:0]   shifted_s;
    logic             ge_s;

    // One restoring step on either the freshly loaded operands or the running state.
    always_comb begin
        src_quo_s = start ? dividend : quo_q;
        src_rem_s = start ? {WIDTH{1'b0}} : rem_q;
        shifted_s = {src_rem_s, src_quo_s[WIDTH-1]};
        ge_s      = (shifted_s >= {1'b0, divisor});
        new_rem_s = ge_s ? (shifted_s[WIDTH-1:0] - divisor) : shifted_s[WIDTH-1:0];

        quo_d   = quo_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (start) begin
            quo_d   = {src_quo_s[WIDTH-2:0], ge_s};
            rem_d   = new_rem_s;
            cnt_d   = CW'(WIDTH - 1);
            valid_d = (WIDTH == 1);
        end else if (cnt_q != {CW{1'b0}}) begin
            quo_d   = {src_quo_s[WIDTH-2:0], ge_s};
            rem_d   = new_rem_s;
            cnt_d   = cnt_q - CW'(1);
            valid_d = (cnt_q == CW'(1));
        end else begin
            valid_d = valid_q;
        end
    end

    // Divider state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            quo_q   <= {WIDTH{1'b0}};
            rem_q   <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
            valid_q <= 1'b0;
        end else begin
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    assign quotient = quo_q;
    assign valid    = valid_q;
endmodule

// File: rtl/gcd_lcm_coproc.sv
// Memory-mapped GCD/LCM coprocessor: subtractive Euclid for the GCD, then
// LCM = (OPA / g) * OPB via the sequential divider and one wide multiply.
module gcd_lcm_coproc
    import gcd_lcm_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0060
) (
    input  logic            clk,
    input  logic            reset,
    gcd_lcm_coproc_if.slave bus
);
    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] g_q, g_d, result_q, result_d;
    logic             busy_q, busy_d, done_q, done_d, zero_err_q, zero_err_d, ovf_q, ovf_d;

    logic [31:0]        off_s;
    logic               in_win_s, reg_wr_s, start_s, div_start_s, div_valid_s;
    logic [WIDTH-1:0]   div_quo_s, rd_s;
    logic [2*WIDTH-1:0] prod_s;

    assign off_s    = bus.DataAdr - BASE_ADDR;
    assign in_win_s = (bus.DataAdr >= BASE_ADDR) && (off_s < WINDOW_BYTES);
    assign reg_wr_s = bus.MemWrite && in_win_s && !busy_q;
    assign start_s  = reg_wr_s && (off_s == OFF_CTRL) && bus.WriteData[CTRL_START];
    assign prod_s   = {ZERO_W, div_quo_s} * {ZERO_W, opb_q};

    // Operands are only writable while idle, so opa_q/opb_q double as the latched copies.
    seq_divider #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start_s),
        .dividend (opa_q),
        .divisor  (g_q),
        .quotient (div_quo_s),
        .valid    (div_valid_s)
    );

    // Register writes and controller next-state.
    always_comb begin
        state_d = state_q;   mode_d = mode_q;     opa_d = opa_q;   opb_d = opb_q;
        a_d = a_q;           b_d = b_q;           g_d = g_q;       result_d = result_q;
        busy_d = busy_q;     done_d = done_q;     zero_err_d = zero_err_q;
        ovf_d = ovf_q;       div_start_s = 1'b0;

        if (reg_wr_s && (off_s == OFF_OPA)) begin
            opa_d = bus.WriteData;
        end else if (reg_wr_s && (off_s == OFF_OPB)) begin
            opb_d = bus.WriteData;
        end else begin
            opa_d = opa_q;
        end

        case (state_q)
            IDLE: begin
                if (start_s) begin
                    mode_d     = mode_e'(bus.WriteData[CTRL_MODE]);
                    a_d        = opa_q;
                    b_d        = opb_q;
                    done_d     = 1'b0;
                    zero_err_d = 1'b0;
                    ovf_d      = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = GCD;
                end else begin
                    state_d = IDLE;
                end
            end
            GCD: begin
                if ((a_q == ZERO_W) || (b_q == ZERO_W)) begin
                    g_d     = a_q | b_q;
                    state_d = CHECK;
                end else if (a_q == b_q) begin
                    g_d     = a_q;
                    state_d = CHECK;
                end else if (a_q > b_q) begin
                    a_d = a_q - b_q;
                end else begin
                    b_d = b_q - a_q;
                end
            end
            CHECK: begin
                if ((opa_q == ZERO_W) && (opb_q == ZERO_W)) begin
                    zero_err_d = 1'b1;
                    result_d   = ZERO_W;
                    state_d    = DONE;
                end else if (mode_q == MODE_GCD) begin
                    result_d = g_q;
                    state_d  = DONE;
                end else if ((opa_q == ZERO_W) || (opb_q == ZERO_W)) begin
                    result_d = ZERO_W;
                    state_d  = DONE;
                end else begin
                    div_start_s = 1'b1;
                    state_d     = DIV;
                end
            end
            DIV: begin
                if (div_valid_s) begin
                    state_d = MUL;
                end else begin
                    state_d = DIV;
                end
            end
            MUL: begin
                result_d = prod_s[WIDTH-1:0];
                ovf_d    = |prod_s[2*WIDTH-1:WIDTH];
                state_d  = DONE;
            end
            DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Read mux; unaligned offsets inside the window read zero.
    always_comb begin
        rd_s = ZERO_W;
        if (in_win_s) begin
            case (off_s)
                OFF_OPA:    rd_s = opa_q;
                OFF_OPB:    rd_s = opb_q;
                OFF_CTRL:   rd_s[CTRL_MODE] = mode_q;
                OFF_STATUS: begin
                    rd_s[ST_BUSY]     = busy_q;
                    rd_s[ST_DONE]     = done_q;
                    rd_s[ST_ZERO_ERR] = zero_err_q;
                    rd_s[ST_OVF]      = ovf_q;
                end
                OFF_RESULT: rd_s = result_q;
                default:    rd_s = ZERO_W;
            endcase
        end else begin
            rd_s = ZERO_W;
        end
    end

    // Controller and register-file state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;       mode_q <= MODE_GCD;    opa_q <= ZERO_W;    opb_q <= ZERO_W;
            a_q <= ZERO_W;         b_q <= ZERO_W;         g_q <= ZERO_W;      result_q <= ZERO_W;
            busy_q <= 1'b0;        done_q <= 1'b0;        zero_err_q <= 1'b0; ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;    mode_q <= mode_d;      opa_q <= opa_d;     opb_q <= opb_d;
            a_q <= a_d;            b_q <= b_d;            g_q <= g_d;         result_q <= result_d;
            busy_q <= busy_d;      done_q <= done_d;      zero_err_q <= zero_err_d; ovf_q <= ovf_d;
        end
    end

    assign bus.rd_data = rd_s;
    assign bus.sel     = in_win_s;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_gcd_lcm_coproc.sv
// Directed, table-driven bench for gcd_lcm_coproc with hand-computed results
// and completion latencies.
module tb_gcd_lcm_coproc;
    localparam logic [31:0] BASE  = 32'h0000_0060;
    localparam int          LIMIT = 70000;

    typedef struct {
        logic [31:0] opa;
        logic [31:0] opb;
        logic        mode;
        logic [31:0] res;
        logic [31:0] status;
        int          cyc;
    } vec_t;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    vec_t vecs[8];

    gcd_lcm_coproc_if #(.WIDTH(32)) bus ();

    gcd_lcm_coproc #(.WIDTH(32), .BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; the store lands on the following posedge.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.MemWrite  = 1'b1;
        bus.DataAdr   = addr;
        bus.WriteData = data;
        @(negedge clk);
        bus.MemWrite  = 1'b0;
        bus.DataAdr   = 32'h0;
        bus.WriteData = 32'h0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data, output logic s);
        @(negedge clk);
        bus.DataAdr = addr;
        #1;
        data = bus.rd_data;
        s    = bus.sel;
        bus.DataAdr = 32'h0;
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic m);
        @(negedge clk);
        wr(BASE, a);
        wr(BASE + 32'd4, b);
        wr(BASE + 32'd8, {30'd0, m, 1'b1});
    endtask

    task automatic wait_done(inout int cyc);
        while (bus.done !== 1'b1 && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        s;
        int          cyc;

        tests = 0;
        fails = 0;
        vecs[0] = '{32'd50,       32'd75,       1'b0, 32'd25,       32'h2, 5};
        vecs[1] = '{32'd4,        32'd6,        1'b1, 32'd12,       32'h2, 38};
        vecs[2] = '{32'd0,        32'd7,        1'b0, 32'd7,        32'h2, 3};
        vecs[3] = '{32'd0,        32'd7,        1'b1, 32'd0,        32'h2, 3};
        vecs[4] = '{32'd0,        32'd0,        1'b0, 32'd0,        32'h6, 3};
        vecs[5] = '{32'd21,       32'd6,        1'b0, 32'd3,        32'h2, 7};
        vecs[6] = '{32'd7,        32'd7,        1'b1, 32'd7,        32'h2, 36};
        vecs[7] = '{32'h0001_0000, 32'h0001_0001, 1'b1, 32'h0001_0000, 32'hA, 65572};

        bus.MemWrite  = 1'b0;
        bus.DataAdr   = 32'h0;
        bus.WriteData = 32'h0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        rd(BASE + 32'd12, d, s); chk("rst_status", d, 32'h0); chk("rst_sel", 32'(s), 32'd1);
        rd(BASE + 32'd16, d, s); chk("rst_result", d, 32'h0);
        rd(BASE, d, s);          chk("rst_opa", d, 32'h0);

        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].opa, vecs[i].opb, vecs[i].mode);
            chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'd1);
            chk($sformatf("v%0d_done_clr", i), 32'(bus.done), 32'd0);
            cyc = 0;
            wait_done(cyc);
            chk($sformatf("v%0d_done", i), 32'(bus.done), 32'd1);
            chk($sformatf("v%0d_latency", i), 32'(cyc), 32'(vecs[i].cyc));
            rd(BASE + 32'd16, d, s);
            chk($sformatf("v%0d_result", i), d, vecs[i].res);
            chk($sformatf("v%0d_sel", i), 32'(s), 32'd1);
            rd(BASE + 32'd12, d, s);
            chk($sformatf("v%0d_status", i), d, vecs[i].status);
            rd(BASE + 32'd8, d, s);
            chk($sformatf("v%0d_ctrl", i), d, {30'd0, vecs[i].mode, 1'b0});
        end

        rd(32'h0000_0100, d, s); chk("out_rd", d, 32'h0); chk("out_sel", 32'(s), 32'd0);
        rd(BASE + 32'd2, d, s);  chk("unaligned_rd", d, 32'h0); chk("unaligned_sel", 32'(s), 32'd1);
        rd(BASE + 32'd20, d, s); chk("past_window_sel", 32'(s), 32'd0);

        // Stores during a computation must not disturb it or restart it.
        start_op(32'd4, 32'd6, 1'b1);
        cyc = 0;
        wr(BASE, 32'd99);             cyc++;
        wr(BASE + 32'd8, 32'd1);      cyc++;
        chk("busy_wr_busy", 32'(bus.busy), 32'd1);
        wait_done(cyc);
        chk("busy_wr_latency", 32'(cyc), 32'd38);
        rd(BASE + 32'd16, d, s); chk("busy_wr_result", d, 32'd12);
        rd(BASE, d, s);          chk("busy_wr_opa", d, 32'd4);
        rd(BASE + 32'd8, d, s);  chk("busy_wr_ctrl", d, 32'h2);
        wr(BASE + 32'd16, 32'd5);
        rd(BASE + 32'd16, d, s); chk("result_ro", d, 32'd12);

        // Reset while the divider is running.
        start_op(32'd4, 32'd6, 1'b1);
        repeat (10) @(negedge clk);
        chk("mid_div_busy", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        rd(BASE + 32'd16, d, s); chk("abort_result", d, 32'h0);
        rd(BASE + 32'd12, d, s); chk("abort_status", d, 32'h0);
        rd(BASE + 32'd8, d, s);  chk("abort_ctrl", d, 32'h0);

        start_op(32'd12, 32'd18, 1'b0);
        cyc = 0;
        wait_done(cyc);
        chk("post_rst_latency", 32'(cyc), 32'd5);
        rd(BASE + 32'd16, d, s); chk("post_rst_result", d, 32'd6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
